// File: rtl/sonic_pkg.sv
// sonic_pkg: shared definitions for the ultrasonic ranging path.
// Holds the ping controller state encoding, default timing constants
// (50 MHz CLOCK_50) and the echo-width to distance scale factor.
package sonic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      HOLDOFF
   } state_t;

   localparam int DEF_TRIG_CYCLES         = 500;      // 10 us trigger pulse
   localparam int DEF_ECHO_TIMEOUT_CYCLES = 1250000;  // 25 ms
   localparam int DEF_PING_PERIOD_CYCLES  = 3000000;  // 60 ms
   localparam int DEF_CNT_W               = 24;

   // Echo clocks per centimetre of range, used by the distance stage.
   localparam int CYCLES_PER_CM = 2900;

endpackage

// File: rtl/sonic_echo_sync.sv
// sonic_echo_sync: brings the asynchronous sensor echo into the CLOCK_50
// domain through two flops and flags its rising and falling edges.
module sonic_echo_sync (
   input  logic clk,
   input  logic reset,
   input  logic echo,
   output logic echo_s,
   output logic rise,
   output logic fall
);

   logic echo_m;
   logic echo_d;

   // Two-flop synchronizer followed by a delay flop for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   assign rise = echo_s & ~echo_d;
   assign fall = ~echo_s & echo_d;

endmodule

// File: rtl/sonic_ping_ctrl.sv
// sonic_ping_ctrl: HC-SR04 trigger generation and echo width timing with
// timeouts on both the wait for echo and the echo width itself.
// Build macro SONIC_AUTO_PING_EN: ping continuously every
// PING_PERIOD_CYCLES from reset release; start is ignored.
module sonic_ping_ctrl
   import sonic_pkg::*;
#(
   parameter int TRIG_CYCLES         = DEF_TRIG_CYCLES,
   parameter int ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES,
   parameter int PING_PERIOD_CYCLES  = DEF_PING_PERIOD_CYCLES,
   parameter int CNT_W               = DEF_CNT_W
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             start,
   input  logic             echo,
   output logic             trigger,
   output logic             busy,
   output logic [CNT_W-1:0] echo_count,
   output logic             count_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ECHO_MAX  = CNT_W'(ECHO_TIMEOUT_CYCLES);
`ifdef SONIC_AUTO_PING_EN
   // HOLDOFF re-enters TRIG directly, so the last holdoff clock is PERIOD-1.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PING_PERIOD_CYCLES - 1);
`else
   // One IDLE clock sits between HOLDOFF and the next TRIG, so leave HOLDOFF
   // one clock early: a start waiting in IDLE then triggers exactly one
   // period after the previous trigger rise.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PING_PERIOD_CYCLES - 2);
`endif

   // Saturating increment: counters stick at all-ones rather than wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cycle, cycle_nxt;
   logic [CNT_W-1:0] period, period_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             valid_nxt;
   logic             tmo_nxt;
   logic             echo_s, rise, fall;

`ifdef SONIC_AUTO_PING_EN
   logic unused_start;
   assign unused_start = start;
`endif

   sonic_echo_sync u_echo_sync (
      .clk    (CLOCK_50),
      .reset  (reset),
      .echo   (echo),
      .echo_s (echo_s),
      .rise   (rise),
      .fall   (fall)
   );

   // State register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state, counter and result logic.
   always_comb begin
      state_nxt  = state;
      cycle_nxt  = cycle;
      period_nxt = (state == IDLE) ? period : sat_inc(period);
      count_nxt  = echo_count;
      valid_nxt  = 1'b0;
      tmo_nxt    = 1'b0;
      case (state)
         IDLE: begin
`ifdef SONIC_AUTO_PING_EN
            state_nxt  = TRIG;
            cycle_nxt  = '0;
            period_nxt = '0;
`else
            if (start) begin
               state_nxt  = TRIG;
               cycle_nxt  = '0;
               period_nxt = '0;
            end
`endif
         end
         TRIG: begin
            if (cycle >= TRIG_LAST) begin
               state_nxt = WAIT_RISE;
               cycle_nxt = '0;
            end else begin
               cycle_nxt = sat_inc(cycle);
            end
         end
         WAIT_RISE: begin
            // Only a fresh low-to-high edge counts; an echo already high here
            // rose before this ping and is ignored.
            if (rise) begin
               state_nxt = MEASURE;
               cycle_nxt = CNT_W'(1);
            end else if (cycle >= WAIT_LAST) begin
               state_nxt = HOLDOFF;
               count_nxt = '0;
               valid_nxt = 1'b1;
               tmo_nxt   = 1'b1;
            end else begin
               cycle_nxt = sat_inc(cycle);
            end
         end
         MEASURE: begin
            if (fall) begin
               state_nxt = HOLDOFF;
               count_nxt = cycle;
               valid_nxt = 1'b1;
            end else if (cycle >= ECHO_MAX) begin
               state_nxt = HOLDOFF;
               count_nxt = ECHO_MAX;
               valid_nxt = 1'b1;
               tmo_nxt   = 1'b1;
            end else if (echo_s) begin
               cycle_nxt = sat_inc(cycle);
            end
         end
         HOLDOFF: begin
            if (period >= HOLD_LAST) begin
`ifdef SONIC_AUTO_PING_EN
               state_nxt  = TRIG;
               cycle_nxt  = '0;
               period_nxt = '0;
`else
               state_nxt  = IDLE;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counters and registered outputs; trigger follows the next state so it
   // comes straight from a flop with no decode glitches.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cycle       <= '0;
         period      <= '0;
         trigger     <= 1'b0;
         echo_count  <= '0;
         count_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         cycle       <= cycle_nxt;
         period      <= period_nxt;
         trigger     <= (state_nxt == TRIG);
         echo_count  <= count_nxt;
         count_valid <= valid_nxt;
         timeout     <= tmo_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/sonic_ping_ctrl.md
Name: sonic_ping_ctrl

Overview:
Upstream stage of the ultrasonic ranging path. It generates the HC-SR04 trigger pulse and times the returned echo. It adds timeouts so a missing or stuck echo cannot hang the channel. It produces one raw echo width per ping, in CLOCK_50 cycles, with a valid strobe; the downstream distance stage converts it at 2900 cycles/cm. One instance per sensor.

Parameters:
TRIG_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz)
ECHO_TIMEOUT_CYCLES, 1250000, maximum wait for echo rise, and maximum echo width (25 ms)
PING_PERIOD_CYCLES, 3000000, minimum spacing between trigger rising edges (60 ms); must be greater than TRIG_CYCLES + 2*ECHO_TIMEOUT_CYCLES
CNT_W, 24, width of echo_count and internal counters

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle ping request
echo  in  1  raw sensor echo, asynchronous
trigger  out  1  sensor trigger pulse
busy  out  1  high whenever state is not IDLE
echo_count  out  CNT_W  last measured echo width in clocks; held between pings
count_valid  out  1  one-cycle strobe: echo_count updated
timeout  out  1  one-cycle strobe, coincident with count_valid, when the ping timed out

Behaviour:
- Single clock CLOCK_50. Reset is synchronous and active-high: on any CLOCK_50 edge with reset=1, state=IDLE, all counters=0, trigger=0, busy=0, echo_count=0, count_valid=0, timeout=0. Reset mid-ping aborts with no strobe.
- echo passes through a 2-flop synchronizer (echo_s), so there are 2 clocks of input latency. An edge detector on echo_s produces rise/fall.
- FSM:
  - IDLE: trigger=0. When start=1, go to TRIG; clear the cycle and period counters.
  - TRIG: trigger=1 for exactly TRIG_CYCLES clocks, then go to WAIT_RISE.
  - WAIT_RISE: wait for an echo_s rising edge, then go to MEASURE with echo counter=1.
    - Echo already high on entry is stale: the ping still needs a low-then-high transition.
    - After ECHO_TIMEOUT_CYCLES clocks with no rise: echo_count=0, count_valid=1, timeout=1, go to HOLDOFF.
  - MEASURE: the echo counter increments each clock while echo_s=1.
    - On echo_s falling edge: echo_count=counter, count_valid=1, timeout=0, go to HOLDOFF.
    - If the counter reaches ECHO_TIMEOUT_CYCLES: echo_count=ECHO_TIMEOUT_CYCLES, count_valid=1, timeout=1, go to HOLDOFF.
  - HOLDOFF: wait until the period counter (started at the TRIG entry) reaches PING_PERIOD_CYCLES, then go to IDLE.
- start while busy=1 is ignored; there is no queueing.
- echo_count changes only on the count_valid cycle. count_valid and timeout last one clock each.
- All counters saturate and never wrap.
- trigger is a registered output, glitch-free.

Optional Feature:
Macro SONIC_AUTO_PING_EN.
- Defined: HOLDOFF goes directly to TRIG instead of IDLE, so the block pings continuously from reset release with period PING_PERIOD_CYCLES. The first ping starts 1 clock after reset deasserts. start is ignored.
- Undefined: pings occur only on start requests, as described above.

Decomposition:
- Package sonic_pkg: the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF), default timing constants, and CYCLES_PER_CM=2900 shared with the distance stage.
- One sub-module, sonic_echo_sync: 2-flop synchronizer plus rise/fall edge detector.

Test Plan (TRIG_CYCLES=5, ECHO_TIMEOUT_CYCLES=100, PING_PERIOD_CYCLES=300):
- Reset held 3 clocks, then start=1 -> trigger high exactly 5 clocks, busy=1, all outputs 0 before start.
- After trigger, echo high 40 clocks -> count_valid pulse, echo_count=40, timeout=0; the next start is accepted only 300 clocks after the previous trigger rise.
- No echo -> 100 clocks after trigger falls, count_valid=1, timeout=1, echo_count=0.
- Echo stuck high 500 clocks -> echo_count=100, timeout=1; echo already high at WAIT_RISE entry is not counted.
- start pulsed during MEASURE and HOLDOFF -> ignored, exactly one trigger per period; reset asserted mid-MEASURE -> trigger=0, busy=0, no count_valid.
- SONIC_AUTO_PING_EN defined, echo 20 clocks every ping -> trigger rises every 300 clocks, echo_count=20 each ping.
